// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage port bundle: memory program port, decode handshake, redirect and status
interface fetch_unit_if #(
  parameter int WORD_SIZE        = 8,
  parameter int INSTRUCTION_SIZE = 16
);
  logic [WORD_SIZE-1:0]        pc;
  logic [INSTRUCTION_SIZE-1:0] current_instruction;
  logic [INSTRUCTION_SIZE-1:0] instr;
  logic [WORD_SIZE-1:0]        instr_pc;
  logic                        instr_valid;
  logic                        instr_ready;
  logic                        jump;
  logic                        call;
  logic                        ret;
  logic [WORD_SIZE-1:0]        target;
  logic [WORD_SIZE-1:0]        link_pc;
  logic                        halt;
  logic                        halted;
  logic                        ras_overflow;
  logic                        ras_underflow;

  // Fetch unit side
  modport master (
    output pc, instr, instr_pc, instr_valid, halted, ras_overflow, ras_underflow,
    input  current_instruction, instr_ready, jump, call, ret, target, link_pc, halt
  );

  // Memory manager / decode / control side
  modport slave (
    input  pc, instr, instr_pc, instr_valid, halted, ras_overflow, ras_underflow,
    output current_instruction, instr_ready, jump, call, ret, target, link_pc, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, instruction register, return-address stack and halt FSM
module fetch_unit #(
  parameter int WORD_SIZE        = 8,
  parameter int INSTRUCTION_SIZE = 16,
  parameter int RAS_DEPTH        = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0]     head;   // next slot to write; when full this is the oldest entry
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     top_idx;
  logic [WORD_SIZE-1:0] pop_dest;

  // Most recent RAS entry, or address 0 when the stack is empty
  always_comb begin
    top_idx  = head - 1'b1;
    pop_dest = '0;
    if (count != '0) pop_dest = ras[top_idx];
  end

  // Fetch FSM: halt > ret > call > jump > sequential fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= RUN;
      bus.pc            <= '0;
      bus.instr         <= '0;
      bus.instr_pc      <= '0;
      bus.instr_valid   <= 1'b0;
      bus.halted        <= 1'b0;
      bus.ras_overflow  <= 1'b0;
      bus.ras_underflow <= 1'b0;
      head              <= '0;
      count             <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.halt) begin
            state           <= HALTED;
            bus.halted      <= 1'b1;
            bus.instr_valid <= 1'b0;
          end else if (bus.ret) begin
            bus.pc          <= pop_dest;
            bus.instr_valid <= 1'b0;
            if (count == '0) begin
              bus.ras_underflow <= 1'b1;
            end else begin
              head  <= top_idx;
              count <= count - 1'b1;
            end
          end else if (bus.call) begin
            bus.pc          <= bus.target;
            bus.instr_valid <= 1'b0;
            ras[head]       <= bus.link_pc;
            head            <= head + 1'b1;
            // A full stack drops its oldest entry, so the depth stays saturated
            if (count == RAS_FULL) bus.ras_overflow <= 1'b1;
            else                   count <= count + 1'b1;
          end else if (bus.jump) begin
            bus.pc          <= bus.target;
            bus.instr_valid <= 1'b0;
          end else if (!bus.instr_valid || bus.instr_ready) begin
            bus.instr       <= bus.current_instruction[INSTRUCTION_SIZE-1:0];
            bus.instr_pc    <= bus.pc;
            bus.instr_valid <= 1'b1;
            bus.pc          <= bus.pc + 1'b1;
          end
        end
        HALTED: begin
          bus.instr_valid <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  fetch_unit_if #(.WORD_SIZE(8), .INSTRUCTION_SIZE(16)) bus ();

  fetch_unit #(.WORD_SIZE(8), .INSTRUCTION_SIZE(16), .RAS_DEPTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Program memory: word at address i is 0x1000 + i
  assign bus.current_instruction = 16'h1000 + {8'h00, bus.pc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    bus.jump = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.halt = 1'b0;
    bus.target = 8'h00; bus.link_pc = 8'h00;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", bus.pc); end
    checks++; if (bus.instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h expected 0000", bus.instr); end
    checks++; if (bus.instr_pc !== 8'h00) begin errors++; $display("FAIL reset_instr_pc: got %h expected 00", bus.instr_pc); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
    checks++; if ({bus.halted, bus.ras_overflow, bus.ras_underflow} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {bus.halted, bus.ras_overflow, bus.ras_underflow}); end
  endtask

  task automatic test_stream_and_backpressure();
    bus.instr_ready = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(k) || bus.instr !== 16'h1000 + 16'(k) || bus.pc !== 8'(k + 1)) begin
        errors++; $display("FAIL stream_%0d: got v=%b ipc=%h instr=%h pc=%h expected v=1 ipc=%h instr=%h pc=%h",
          k, bus.instr_valid, bus.instr_pc, bus.instr, bus.pc, 8'(k), 16'h1000 + 16'(k), 8'(k + 1)); end
    end
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h05 || bus.pc !== 8'h06) begin
        errors++; $display("FAIL stall_%0d: got v=%b ipc=%h pc=%h expected v=1 ipc=05 pc=06", k, bus.instr_valid, bus.instr_pc, bus.pc); end
    end
    bus.instr_ready = 1'b1;
    step();
    checks++; if (bus.instr_pc !== 8'h06 || bus.instr !== 16'h1006 || bus.pc !== 8'h07) begin
      errors++; $display("FAIL stall_release: got ipc=%h instr=%h pc=%h expected ipc=06 instr=1006 pc=07", bus.instr_pc, bus.instr, bus.pc); end
  endtask

  task automatic test_jump();
    bus.instr_ready = 1'b0;
    bus.jump = 1'b1; bus.target = 8'h40;
    step();
    clear_ctrl();
    checks++; if (bus.instr_valid !== 1'b0 || bus.pc !== 8'h40) begin
      errors++; $display("FAIL jump_bubble: got v=%b pc=%h expected v=0 pc=40", bus.instr_valid, bus.pc); end
    step();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h40 || bus.instr !== 16'h1040 || bus.pc !== 8'h41) begin
      errors++; $display("FAIL jump_target: got v=%b ipc=%h instr=%h pc=%h expected v=1 ipc=40 instr=1040 pc=41",
        bus.instr_valid, bus.instr_pc, bus.instr, bus.pc); end
  endtask

  task automatic test_call_ret();
    logic [7:0] exp_dest [5];
    exp_dest[0] = 8'h15; exp_dest[1] = 8'h14; exp_dest[2] = 8'h13; exp_dest[3] = 8'h12; exp_dest[4] = 8'h00;
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.call = 1'b1; bus.link_pc = 8'h11 + 8'(k); bus.target = 8'h80 + 8'(k);
      step();
      checks++; if (bus.instr_valid !== 1'b0 || bus.pc !== 8'h80 + 8'(k)) begin
        errors++; $display("FAIL call_%0d: got v=%b pc=%h expected v=0 pc=%h", k, bus.instr_valid, bus.pc, 8'h80 + 8'(k)); end
      checks++; if (bus.ras_overflow !== (k == 4)) begin
        errors++; $display("FAIL call_overflow_%0d: got %b expected %b", k, bus.ras_overflow, k == 4); end
    end
    clear_ctrl();
    for (int k = 0; k < 5; k++) begin
      bus.ret = 1'b1;
      step();
      checks++; if (bus.instr_valid !== 1'b0 || bus.pc !== exp_dest[k]) begin
        errors++; $display("FAIL ret_%0d: got v=%b pc=%h expected v=0 pc=%h", k, bus.instr_valid, bus.pc, exp_dest[k]); end
      checks++; if (bus.ras_underflow !== (k == 4)) begin
        errors++; $display("FAIL ret_underflow_%0d: got %b expected %b", k, bus.ras_underflow, k == 4); end
    end
    clear_ctrl();
  endtask

  task automatic test_priority_and_halt();
    bus.call = 1'b1; bus.link_pc = 8'h21; bus.target = 8'h30;
    step();
    bus.link_pc = 8'h22; bus.target = 8'h31;
    step();
    bus.ret = 1'b1; bus.call = 1'b1; bus.jump = 1'b1; bus.link_pc = 8'h99; bus.target = 8'h50;
    step();
    clear_ctrl();
    checks++; if (bus.pc !== 8'h22 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL prio_ret: got pc=%h v=%b expected pc=22 v=0", bus.pc, bus.instr_valid); end
    bus.ret = 1'b1;
    step();
    clear_ctrl();
    checks++; if (bus.pc !== 8'h21) begin errors++; $display("FAIL prio_no_push: got pc=%h expected 21", bus.pc); end
    step();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h21 || bus.pc !== 8'h22) begin
      errors++; $display("FAIL prio_resume: got v=%b ipc=%h pc=%h expected v=1 ipc=21 pc=22", bus.instr_valid, bus.instr_pc, bus.pc); end
    bus.halt = 1'b1; bus.jump = 1'b1; bus.target = 8'h70;
    step();
    checks++; if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pc !== 8'h22) begin
      errors++; $display("FAIL halt_enter: got h=%b v=%b pc=%h expected h=1 v=0 pc=22", bus.halted, bus.instr_valid, bus.pc); end
    bus.halt = 1'b0; bus.ret = 1'b1; bus.call = 1'b1; bus.instr_ready = 1'b1;
    step(); step();
    clear_ctrl();
    checks++; if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pc !== 8'h22) begin
      errors++; $display("FAIL halt_hold: got h=%b v=%b pc=%h expected h=1 v=0 pc=22", bus.halted, bus.instr_valid, bus.pc); end
  endtask

  task automatic test_wrap_and_async_reset();
    reset = 1'b1;
    #1;
    checks++; if ({bus.halted, bus.ras_overflow, bus.ras_underflow, bus.instr_valid} !== 4'b0000 || bus.pc !== 8'h00) begin
      errors++; $display("FAIL reset_from_halt: got h=%b ov=%b un=%b v=%b pc=%h expected all zero",
        bus.halted, bus.ras_overflow, bus.ras_underflow, bus.instr_valid, bus.pc); end
    step();
    reset = 1'b0;
    bus.call = 1'b1; bus.link_pc = 8'h33; bus.target = 8'hFE;
    step();
    clear_ctrl();
    checks++; if (bus.pc !== 8'hFE) begin errors++; $display("FAIL wrap_start: got pc=%h expected FE", bus.pc); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'hFE + 8'(k) || bus.pc !== 8'hFF + 8'(k)) begin
        errors++; $display("FAIL wrap_%0d: got v=%b ipc=%h pc=%h expected v=1 ipc=%h pc=%h",
          k, bus.instr_valid, bus.instr_pc, bus.pc, 8'hFE + 8'(k), 8'hFF + 8'(k)); end
    end
    reset = 1'b1;
    #2;
    checks++; if (bus.pc !== 8'h00 || bus.instr !== 16'h0000 || bus.instr_pc !== 8'h00 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got pc=%h instr=%h ipc=%h v=%b expected all zero",
        bus.pc, bus.instr, bus.instr_pc, bus.instr_valid); end
    step();
    reset = 1'b0;
    bus.ret = 1'b1;
    step();
    clear_ctrl();
    checks++; if (bus.pc !== 8'h00 || bus.ras_underflow !== 1'b1) begin
      errors++; $display("FAIL ras_cleared: got pc=%h un=%b expected pc=00 un=1", bus.pc, bus.ras_underflow); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.instr_ready = 1'b0;
    clear_ctrl();
    test_reset();
    test_stream_and_backpressure();
    test_jump();
    test_call_ret();
    test_priority_and_halt();
    test_wrap_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the memory manager's program port. Owns the program counter, drives `pc` into the memory manager, and captures the combinationally returned `current_instruction` into a one-entry instruction register. The register is handed to decode over a valid/ready handshake. Also handles jump/call/return redirects through an internal return-address stack (RAS), and implements a halt state.

## Interface
- WORD_SIZE, 8: width of `pc` and all addresses; program space is 2^WORD_SIZE entries.
- INSTRUCTION_SIZE, 16: instruction width.
- RAS_DEPTH, 4: return-address stack entries; must be a power of two, ≥ 2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- pc  out  WORD_SIZE  fetch address to memory manager.
- current_instruction  in  INSTRUCTION_SIZE  program word at `pc`, combinational from memory manager.
- instr  out  INSTRUCTION_SIZE  registered instruction to decode.
- instr_pc  out  WORD_SIZE  address `instr` was fetched from.
- instr_valid  out  1  `instr` / `instr_pc` hold a live instruction.
- instr_ready  in  1  decode accepts `instr` this cycle.
- jump  in  1  redirect to `target`.
- call  in  1  push `link_pc`, redirect to `target`.
- ret  in  1  pop RAS, redirect to popped address.
- target  in  WORD_SIZE  jump/call destination.
- link_pc  in  WORD_SIZE  return address pushed on call.
- halt  in  1  enter HALTED.
- halted  out  1  FSM is in HALTED.
- ras_overflow  out  1  sticky: a push occurred while the RAS was full.
- ras_underflow  out  1  sticky: a pop occurred while the RAS was empty.

## Operation
- Reset values: `pc`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, `halted`=0, `ras_overflow`=0, `ras_underflow`=0. RAS count=0, FSM=RUN.
- FSM has two states, RUN and HALTED. RUN→HALTED on `halt`=1. HALTED is left only by reset.
- RUN, no redirect, load condition (`instr_valid`=0 or `instr_ready`=1):
  - `instr`←`current_instruction`, `instr_pc`←`pc`, `instr_valid`←1.
  - `pc`←`pc`+1 modulo 2^WORD_SIZE, so 0xFF wraps to 0x00.
- RUN, no redirect, `instr_valid`=1 and `instr_ready`=0: `pc`, `instr`, `instr_pc` and `instr_valid` all hold.
- Redirect is any of jump/call/ret = 1. It flushes: `instr_valid`←0 and `pc`←destination, regardless of `instr_ready`. A handshake completing in the same cycle still counts as accepted.
- Priority when several are set: halt > ret > call > jump. Lower-priority requests in that cycle are discarded, with no RAS side effects.
- call: push `link_pc`.
  - Push when full overwrites the oldest entry, count stays RAS_DEPTH, `ras_overflow`←1.
- ret: pop the most recent entry; destination is the popped value.
  - Pop when empty: destination 0, count stays 0, `ras_underflow`←1.
- RAS is circular (head pointer plus count). Push and pop never occur in the same cycle.
- HALTED: `instr_valid`=0, `halted`=1, `pc` frozen at its value on entry. All of jump/call/ret/instr_ready are ignored.
- halt in RUN: `instr_valid`←0, `pc` holds; any redirect that cycle is discarded.

## Timing
- All outputs are registered; none depends combinationally on inputs.
- First edge after reset release: `instr_valid`=1, `instr`=word@0, `instr_pc`=0, `pc`=1.
- Sustained throughput with `instr_ready`=1: one instruction per cycle.
- Redirect sampled at edge N: `pc`=dest and `instr_valid`=0 after N. Word@dest is valid after N+1. This is exactly one bubble.
- halt sampled at edge N: `halted`=1 and `instr_valid`=0 after N.
- Reset asserted mid-operation: outputs go to reset values without waiting for a clock edge. RAS is emptied and the sticky flags are cleared.

## Test plan
- Reset release, `instr_ready`=1, program words 0x1000+i at address i: `instr_pc` sequence 0,1,2,…; `instr`=0x1000,0x1001,…; `instr_valid` high from the first edge.
- Back-pressure: hold `instr_ready`=0 for 3 cycles at `instr_pc`=5: `instr_pc`=5 and `pc`=6 stay stable; on release the next output is `instr_pc`=6.
- jump target=0x40 while `instr_valid`=1, `instr_ready`=0: one cycle with `instr_valid`=0 and `pc`=0x40, then `instr_pc`=0x40.
- Five calls with link 0x11..0x15 (RAS_DEPTH=4), then five rets:
  - Destinations 0x15, 0x14, 0x13, 0x12, then 0x00.
  - `ras_overflow`=1 after the fifth call; `ras_underflow`=1 after the fifth ret.
- Same-cycle ret+call+jump with RAS top 0x22: destination 0x22, no push, count decremented. Then halt+jump: `halted`=1, `pc` unchanged.
- Run from `pc`=0xFE: `instr_pc` 0xFE, 0xFF, 0x00. Assert reset mid-stream without a clock edge: all outputs go to zero immediately.
